nes_joypad: RTL



---
 rtl/nes_pkg.sv | 31 +++
 rtl/nes_joypad_sr.sv | 29 ++
 rtl/nes_joypad.sv | 135 +++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// Shared NES controller-port constants: bus addresses and button bit indices.
// Also provides the turbo overlay helper used when NES_JOYPAD_TURBO_EN is defined.
package nes_pkg;

    localparam logic [15:0] ADDR_JOY1 = 16'h4016;
    localparam logic [15:0] ADDR_JOY2 = 16'h4017;

    localparam int NUM_BTNS  = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Turbo overlay: A and B are forced on during the active turbo phase.
    function automatic logic [NUM_BTNS-1:0] turbo_mask(
        input logic [1:0] turbo,
        input logic       phase
    );
        logic [NUM_BTNS-1:0] m;
        m = '0;
        m[BTN_A] = turbo[0] & phase;
        m[BTN_B] = turbo[1] & phase;
        return m;
    endfunction

endpackage

// File: rtl/nes_joypad_sr.sv
// One 4021-style 8-bit parallel-in/serial-out register.
// Load wins over shift; shifting fills from the top with 1s.
module nes_joypad_sr
    import nes_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                shift,
    input  logic [NUM_BTNS-1:0] din,
    output logic                sout
);

    logic [NUM_BTNS-1:0] sh;

    // Parallel load while strobed, otherwise shift once per completed read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh <= '0;
        end else if (load) begin
            sh <= din;
        end else if (shift) begin
            sh <= {1'b1, sh[NUM_BTNS-1:1]};
        end
    end

    assign sout = sh[0];

endmodule

// File: rtl/nes_joypad.sv
// CPU-side responder for the NES controller ports at $4016/$4017.
// Optional turbo A/B overlay is enabled by defining NES_JOYPAD_TURBO_EN.
module nes_joypad
    import nes_pkg::*;
#(
    parameter logic [7:0] OPEN_BUS  = 8'h40,
    parameter int         TURBO_DIV = 416667
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce_cpu,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_o,
    input  logic        cpu_r,
    input  logic        cpu_w,
    input  logic [7:0]  joy1,
    input  logic [7:0]  joy2,
`ifdef NES_JOYPAD_TURBO_EN
    input  logic [1:0]  turbo1,
    input  logic [1:0]  turbo2,
`endif
    output logic [7:0]  dout,
    output logic        hit,
    output logic        strobe_o
);

    logic [7:0] joy_m1;
    logic [7:0] joy_m2;
    logic [7:0] joy_s1;
    logic [7:0] joy_s2;
    logic       strobe;
    logic       sel1;
    logic       sel2;
    logic       shift1;
    logic       shift2;
    logic [7:0] load1;
    logic [7:0] load2;
    logic       bit1;
    logic       bit2;

    assign sel1 = (cpu_a == ADDR_JOY1);
    assign sel2 = (cpu_a == ADDR_JOY2);

    // Two-flop synchronisers for the asynchronous button inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            joy_m1 <= '0;
            joy_m2 <= '0;
            joy_s1 <= '0;
            joy_s2 <= '0;
        end else begin
            joy_m1 <= joy1;
            joy_m2 <= joy2;
            joy_s1 <= joy_m1;
            joy_s2 <= joy_m2;
        end
    end

    // Strobe latch follows bit0 of completed writes to $4016 only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            strobe <= 1'b0;
        end else if (ce_cpu && cpu_w && sel1) begin
            strobe <= cpu_o[0];
        end
    end

`ifdef NES_JOYPAD_TURBO_EN
    localparam int CW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(TURBO_DIV - 1);

    logic [CW-1:0] turbo_cnt;
    logic          turbo_ph;

    // Free-running divider; phase flips once per TURBO_DIV clocks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            turbo_cnt <= '0;
            turbo_ph  <= 1'b0;
        end else if (turbo_cnt == DIV_LAST) begin
            turbo_cnt <= '0;
            turbo_ph  <= ~turbo_ph;
        end else begin
            turbo_cnt <= turbo_cnt + 1'b1;
        end
    end

    assign load1 = joy_s1 | turbo_mask(turbo1, turbo_ph);
    assign load2 = joy_s2 | turbo_mask(turbo2, turbo_ph);
`else
    assign load1 = joy_s1;
    assign load2 = joy_s2;
`endif

    // A read only advances the register on a completed bus cycle.
    assign shift1 = ce_cpu & cpu_r & sel1 & ~strobe;
    assign shift2 = ce_cpu & cpu_r & sel2 & ~strobe;

    nes_joypad_sr u_sr1 (
        .clock (clock),
        .reset (reset),
        .load  (strobe),
        .shift (shift1),
        .din   (load1),
        .sout  (bit1)
    );

    nes_joypad_sr u_sr2 (
        .clock (clock),
        .reset (reset),
        .load  (strobe),
        .shift (shift2),
        .din   (load2),
        .sout  (bit2)
    );

    // Read mux: open-bus upper bits with serial data in bit0.
    always_comb begin
        dout = 8'h00;
        if (!reset) begin
            if (sel1) begin
                dout = {OPEN_BUS[7:1], bit1};
            end else if (sel2) begin
                dout = {OPEN_BUS[7:1], bit2};
            end
        end
    end

    assign hit      = (sel1 | sel2) & cpu_r;
    assign strobe_o = strobe;

    logic unused_bits;
    assign unused_bits = ^{cpu_o[7:1], OPEN_BUS[0], TURBO_DIV[0]};

endmodule
